// File: rtl/dispense_pulse_driver.sv
// Stretches single-cycle request pulses into HOLD/GAP output windows, queueing extras.
// Optional abort input when PULSE_DRIVER_ABORT_EN is defined.
module dispense_pulse_driver #(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 200,
  parameter int QDEPTH      = 3,
  localparam int TMAX =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES,
  localparam int TW = $clog2(TMAX + 1),
  localparam int PW = $clog2(QDEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          pi,
`ifdef PULSE_DRIVER_ABORT_EN
  input  logic          abort,
`endif
  output logic          lo,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PFULL   = PW'(QDEPTH);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          t_zero;
  logic          full;

  assign t_zero = (timer_q == '0);
  assign full   = (pend_q == PFULL);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (pi) begin
          state_d = HOLD;
          timer_d = HOLD_LD;
        end
      end
      HOLD: begin
        if (!t_zero) begin
          timer_d = timer_q - 1'b1;
        end else begin
          state_d = GAP;
          timer_d = GAP_LD;
        end
        if (pi) begin
          if (full) ovf_d = 1'b1;
          else      pend_d = pend_q + 1'b1;
        end
      end
      GAP: begin
        if (!t_zero) begin
          timer_d = timer_q - 1'b1;
          if (pi) begin
            if (full) ovf_d = 1'b1;
            else      pend_d = pend_q + 1'b1;
          end
        end else if (pend_q != '0) begin
          // dequeue; a coincident request takes the freed slot
          state_d = HOLD;
          timer_d = HOLD_LD;
          if (!pi) pend_d = pend_q - 1'b1;
        end else if (pi) begin
          state_d = HOLD;
          timer_d = HOLD_LD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
`ifdef PULSE_DRIVER_ABORT_EN
    if (abort) begin
      state_d = IDLE;
      timer_d = '0;
      pend_d  = '0;
      ovf_d   = ovf_q;
    end
`endif
    lo_d   = (state_d == HOLD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      lo_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign lo      = lo_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_dispense_pulse_driver.sv
// Randomized + directed bench for dispense_pulse_driver against a cycle-count model.
// Define PULSE_DRIVER_ABORT_EN to also exercise the abort input.
module tb_dispense_pulse_driver;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int QD   = 2;
  localparam int PW   = $clog2(QD + 1);

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          pi  = 1'b0;
  logic          ab  = 1'b0;
  logic          lo;
  logic          busy;
  logic [PW-1:0] pending;
  logic          ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // model: service in progress, elapsed cycles within it, queue count
  bit m_act;
  int m_e;
  int m_pend;
  bit m_ovf;

  dispense_pulse_driver #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .QDEPTH     (QD)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .pi     (pi),
`ifdef PULSE_DRIVER_ABORT_EN
    .abort  (ab),
`endif
    .lo     (lo),
    .busy   (busy),
    .pending(pending),
    .ovf    (ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_act  = 0;
    m_e    = 0;
    m_pend = 0;
    m_ovf  = 0;
  endtask

  task automatic mdl_tick(input bit p, input bit a);
    if (a) begin
      m_act  = 0;
      m_e    = 0;
      m_pend = 0;
    end else if (!m_act) begin
      if (p) begin
        m_act = 1;
        m_e   = 0;
      end
    end else if (m_e == HOLD + GAP - 1) begin
      if (m_pend > 0) begin
        m_e = 0;
        if (!p) m_pend--;
      end else if (p) begin
        m_e = 0;
      end else begin
        m_act = 0;
      end
    end else begin
      m_e++;
      if (p) begin
        if (m_pend < QD) m_pend++;
        else             m_ovf = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("lo", int'(lo), int'(m_act && m_e < HOLD));
    chk("busy", int'(busy), int'(m_act));
    chk("pending", int'(pending), m_pend);
    chk("ovf", int'(ovf), int'(m_ovf));
  endtask

  task automatic step(input bit p, input bit a = 1'b0);
    pi = p;
    ab = a;
    @(posedge Clk);
    mdl_tick(p, a);
    #1;
    check_all();
  endtask

  task automatic hard_reset();
    Rst = 1'b1;
    #2;
    chk("rst_lo", int'(lo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovf", int'(ovf), 0);
    Rst = 1'b0;
    mdl_reset();
  endtask

  initial begin
    mdl_reset();
    // reset asserted before any clock edge
    #1;
    hard_reset();

    // single request: lo cycles 1-4, gap 5-6, idle at 7
    step(1);
    for (int i = 0; i < 7; i++) step(0);
    chk("single_idle", int'(busy), 0);

    // pi at 0,2,3,4: queue fills, fourth request dropped
    step(1);
    step(0);
    step(1);
    chk("q_pend1", int'(pending), 1);
    step(1);
    chk("q_pend2", int'(pending), 2);
    step(1);
    chk("q_pend_sat", int'(pending), 2);
    chk("q_ovf", int'(ovf), 1);
    for (int i = 0; i < 20; i++) step(0);
    chk("q_done", int'(busy), 0);
    hard_reset();

    // pending=1 and pi in last gap cycle: pending held, back-to-back hold
    step(1);
    step(0);
    step(1);
    for (int i = 0; i < 3; i++) step(0);
    step(1);
    chk("lg_pend", int'(pending), 1);
    chk("lg_lo", int'(lo), 1);
    for (int i = 0; i < 20; i++) step(0);

    // pending=0 and pi in last gap cycle: direct restart
    step(1);
    for (int i = 0; i < 5; i++) step(0);
    step(1);
    chk("lg0_lo", int'(lo), 1);
    chk("lg0_pend", int'(pending), 0);
    for (int i = 0; i < 10; i++) step(0);

    // reset pulsed between edges mid-hold
    step(1);
    step(0);
    hard_reset();
    for (int i = 0; i < 3; i++) step(0);

`ifdef PULSE_DRIVER_ABORT_EN
    step(1);
    step(1);
    step(1);
    step(1, 1'b1);
    chk("ab_lo", int'(lo), 0);
    chk("ab_pend", int'(pending), 0);
    chk("ab_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) step(0);
`endif

    // random traffic, sparse then dense, with occasional resets
    for (int r = 0; r < 3; r++) begin
      hard_reset();
      for (int i = 0; i < 300; i++) begin
        bit p;
        bit a;
        p = ($urandom_range(0, 7) < (r == 1 ? 5 : 2));
        a = 1'b0;
`ifdef PULSE_DRIVER_ABORT_EN
        a = ($urandom_range(0, 63) == 0);
`endif
        step(p, a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
